conv_row_scheduler: RTL and testbench
=====================================

# conv_row_scheduler

Sequences one `base_block` 1-D convolution datapath through the KERNEL rows of a KERNEL×KERNEL 2-D convolution to produce one output row. For each kernel row it fetches a filter row and a feature row from row memories, and drives them onto the datapath. The previous partial sums go back into the datapath's bias input. After KERNEL passes it presents the finished output row on a valid/ready port. It sits between the layer control logic and the `base_block` instance.

## Interface
- BITS, 16, operand width (filter and feature samples, signed)
- KERNEL, 7, taps per row and rows per job
- FEATURES, 12, feature samples per row; N = FEATURES-KERNEL+1 outputs
- OVERHEAD_BITS, 12, accumulator headroom; W = 2*BITS+OVERHEAD_BITS
- PIPE_LAT, 6, datapath latency in cycles from stable inputs to valid `sums`; legal range ≥1
- ADDR_W, 10, feature-row address width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  job request, sampled only in IDLE
- base_row  in  ADDR_W  first feature row of the job, sampled with start
- bias_in  in  W  signed bias, sampled with start, replicated to all N lanes
- busy  out  1  high from the cycle after start is accepted until the output handshake completes
- rd_en  out  1  row-memory read strobe
- feat_addr  out  ADDR_W  feature row address
- filt_addr  out  $clog2(KERNEL)  filter row index
- feat_rd_data  in  FEATURES*BITS  feature row; valid exactly 1 cycle after rd_en
- filt_rd_data  in  KERNEL*BITS  filter row; valid exactly 1 cycle after rd_en
- dp_filters  out  KERNEL*BITS  to datapath `filters`
- dp_features  out  FEATURES*BITS  to datapath `features`
- dp_biases  out  N*W  to datapath `biases`
- dp_sums  in  N*W  from datapath `sums`
- out_sums  out  N*W  finished row, lane i at bits [(i+1)*W-1 : i*W]
- out_valid  out  1  out_sums valid
- out_ready  in  1  consumer accepts

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, OUT. Row counter k runs 0..KERNEL-1. Wait counter runs 0..PIPE_LAT-1.
- IDLE: when start=1, capture base_row and bias_in, set k=0, load every accumulator lane with bias_in, and go to FETCH. When start=0, stay in IDLE.
- FETCH, 1 cycle: rd_en=1, feat_addr=base_row+k (mod 2^ADDR_W, wraps), filt_addr=k. Go to ISSUE.
- ISSUE, 1 cycle: register the read data into dp_features and dp_filters, and register the accumulator into dp_biases. Go to WAIT.
- WAIT, PIPE_LAT cycles: dp_* stay stable. On the last WAIT cycle, capture dp_sums into the accumulator. Then, if k=KERNEL-1, go to OUT; otherwise increment k and go to FETCH.
- OUT: out_valid=1 and out_sums=accumulator (post-processed, see Configuration). When out_ready=1, go to IDLE.
- Arithmetic: the controller performs no additions. Accumulation happens through the datapath bias chain, and W-bit wraparound is the datapath's.
- A start pulse outside IDLE is ignored, and no queueing occurs.
- rst at any cycle, including mid-job: on the next edge go to IDLE and abandon the job.

## Timing
- Reset values: busy=0, rd_en=0, feat_addr=0, filt_addr=0, dp_filters=0, dp_features=0, dp_biases=0, out_sums=0, out_valid=0. Accumulator and counters are also 0.
- start is accepted at cycle 0. Row k FETCH occurs at cycle 1+k*(PIPE_LAT+2). The accumulator capture edge for row k ends cycle (k+1)*(PIPE_LAT+2).
- out_valid first rises at cycle KERNEL*(PIPE_LAT+2)+1. With the defaults this is cycle 57.
- out_valid and out_sums hold until out_ready. The handshake completes in any cycle where out_valid&out_ready=1, and busy falls on the following cycle.
- The earliest next start is accepted the cycle after returning to IDLE.

## Configuration
- CONV_SAT_EN defined: each OUT lane is saturated to the signed 2*BITS range. Values above 2^(2*BITS-1)-1 clamp to that maximum, values below -2^(2*BITS-1) clamp to that minimum, and the result is sign-extended to W. Saturation is applied combinationally on out_sums only; the accumulator is unaffected.
- CONV_SAT_EN undefined: out_sums = accumulator, with no clamp logic.

## Structure
- The shared package `conv_pkg` holds: the state enum, the localparams N and W, and a function `lane_sat` (used only under CONV_SAT_EN).
- One sub-module: `conv_wait_timer`, a loadable down-counter of $clog2(PIPE_LAT+1) bits with `load`/`expire`, used for the WAIT state.
- The bench pairs the scheduler with a behavioural `base_block` model that has exact PIPE_LAT latency and a 1-cycle-latency row-memory model.

## Test plan
- Reset, then idle with start=0 for 20 cycles → all outputs stay 0 and busy=0.
- All filters=1, all features=1, bias_in=5, defaults → out_valid at cycle 57. Every lane = 5 + 7*7 = 54. rd_en pulses exactly 7 times, with feat_addr base_row..base_row+6.
- base_row=2^ADDR_W-3 → feat_addr sequence wraps: 1021, 1022, 1023, 0, 1, 2, 3.
- Hold out_ready=0 for 10 cycles after out_valid → out_sums stable and busy=1. Extra start pulses in that window are ignored. Raise out_ready → busy falls the next cycle.
- Assert rst at cycle 20 of a job → next cycle IDLE with all outputs 0. A new start then yields a correct, uncorrupted result.
- CONV_SAT_EN: filters=0x7FFF, features=0x7FFF, bias_in=0 → every lane = 0x7FFFFFFF sign-extended. Without the macro → raw 49*0x3FFF0001.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution row scheduler.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  localparam int CONV_BITS          = 16;
  localparam int CONV_KERNEL        = 7;
  localparam int CONV_FEATURES      = 12;
  localparam int CONV_OVERHEAD_BITS = 12;
  localparam int N = CONV_FEATURES - CONV_KERNEL + 1;
  localparam int W = 2 * CONV_BITS + CONV_OVERHEAD_BITS;

  // Clamp a sign-extended lane to the signed range of p_bits bits.
  function automatic logic signed [63:0] lane_sat(input logic signed [63:0] v,
                                                  input int unsigned p_bits);
    logic signed [63:0] v_max;
    logic signed [63:0] v_min;
    v_max = (64'sd1 <<< (p_bits - 1)) - 64'sd1;
    v_min = -(64'sd1 <<< (p_bits - 1));
    if (v > v_max)      lane_sat = v_max;
    else if (v < v_min) lane_sat = v_min;
    else                lane_sat = v;
  endfunction

endpackage

// File: rtl/conv_wait_timer.sv
// Loadable down-counter that marks the last cycle of a PIPE_LAT-long wait.
module conv_wait_timer #(
  parameter int PIPE_LAT = 6
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_expire
);

  localparam int CW = $clog2(PIPE_LAT + 1);

  logic [CW-1:0] r_cnt;

  // Loading PIPE_LAT-1 makes the count reach zero on the PIPE_LAT-th cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(PIPE_LAT - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/conv_row_scheduler.sv
// Drives one 1-D conv datapath through KERNEL rows, chaining partial sums via bias.
// Optional macro CONV_SAT_EN clamps each output lane to the signed 2*BITS range.
module conv_row_scheduler
  import conv_pkg::*;
#(
  parameter int BITS          = CONV_BITS,
  parameter int KERNEL        = CONV_KERNEL,
  parameter int FEATURES      = CONV_FEATURES,
  parameter int OVERHEAD_BITS = CONV_OVERHEAD_BITS,
  parameter int PIPE_LAT      = 6,
  parameter int ADDR_W        = 10
) (
  input  logic                                                    i_clk,
  input  logic                                                    i_rst,
  input  logic                                                    i_start,
  input  logic [ADDR_W-1:0]                                       i_base_row,
  input  logic [2*BITS+OVERHEAD_BITS-1:0]                         i_bias_in,
  output logic                                                    o_busy,
  output logic                                                    o_rd_en,
  output logic [ADDR_W-1:0]                                       o_feat_addr,
  output logic [$clog2(KERNEL)-1:0]                               o_filt_addr,
  input  logic [FEATURES*BITS-1:0]                                i_feat_rd_data,
  input  logic [KERNEL*BITS-1:0]                                  i_filt_rd_data,
  output logic [KERNEL*BITS-1:0]                                  o_dp_filters,
  output logic [FEATURES*BITS-1:0]                                o_dp_features,
  output logic [(FEATURES-KERNEL+1)*(2*BITS+OVERHEAD_BITS)-1:0]   o_dp_biases,
  input  logic [(FEATURES-KERNEL+1)*(2*BITS+OVERHEAD_BITS)-1:0]   i_dp_sums,
  output logic [(FEATURES-KERNEL+1)*(2*BITS+OVERHEAD_BITS)-1:0]   o_out_sums,
  output logic                                                    o_out_valid,
  input  logic                                                    i_out_ready,
  output logic [2:0]                                              o_state
);

  localparam int LANES = FEATURES - KERNEL + 1;
  localparam int ACC_W = 2 * BITS + OVERHEAD_BITS;
  localparam int KW    = $clog2(KERNEL);
  localparam logic [KW-1:0] K_LAST = KW'(KERNEL - 1);

  state_t                     r_state;
  state_t                     w_next;
  logic [ADDR_W-1:0]          r_base;
  logic [KW-1:0]              r_k;
  logic [LANES*ACC_W-1:0]     r_acc;
  logic [KERNEL*BITS-1:0]     r_filters;
  logic [FEATURES*BITS-1:0]   r_features;
  logic [LANES*ACC_W-1:0]     r_biases;
  logic                       w_load;
  logic                       w_expire;

  conv_wait_timer #(.PIPE_LAT(PIPE_LAT)) u_wait_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (w_load),
    .o_expire (w_expire)
  );

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_FETCH;
      ST_FETCH: w_next = ST_ISSUE;
      ST_ISSUE: begin
        w_next = ST_WAIT;
        w_load = 1'b1;
      end
      ST_WAIT:  if (w_expire) w_next = (r_k == K_LAST) ? ST_OUT : ST_FETCH;
      ST_OUT:   if (i_out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_filters  <= '0;
      r_features <= '0;
      r_biases   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (i_start) begin
          r_base <= i_base_row;
          r_k    <= '0;
          r_acc  <= {LANES{i_bias_in}};
        end
        ST_ISSUE: begin
          r_features <= i_feat_rd_data;
          r_filters  <= i_filt_rd_data;
          r_biases   <= r_acc;
        end
        // The datapath already added this row onto the bias chain.
        ST_WAIT: if (w_expire) begin
          r_acc <= i_dp_sums;
          if (r_k != K_LAST) r_k <= r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != ST_IDLE);
  assign o_rd_en       = (r_state == ST_FETCH);
  assign o_feat_addr   = r_base + ADDR_W'(r_k);
  assign o_filt_addr   = r_k;
  assign o_dp_filters  = r_filters;
  assign o_dp_features = r_features;
  assign o_dp_biases   = r_biases;
  assign o_out_valid   = (r_state == ST_OUT);
  assign o_state       = r_state;

`ifdef CONV_SAT_EN
  for (genvar g = 0; g < LANES; g++) begin : g_sat
    logic signed [63:0] w_ext;
    logic signed [63:0] w_clamped;
    assign w_ext     = 64'(signed'(r_acc[g*ACC_W +: ACC_W]));
    assign w_clamped = lane_sat(w_ext, 2 * BITS);
    assign o_out_sums[g*ACC_W +: ACC_W] = w_clamped[ACC_W-1:0];
  end
`else
  assign o_out_sums = r_acc;
`endif

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Directed bench: scheduler + behavioural datapath and 1-cycle row memories.
module tb_conv_row_scheduler;

  localparam int BITS     = 16;
  localparam int KERNEL   = 7;
  localparam int FEATURES = 12;
  localparam int OVH      = 12;
  localparam int PIPE_LAT = 6;
  localparam int ADDR_W   = 10;
  localparam int NL       = FEATURES - KERNEL + 1;
  localparam int WL       = 2 * BITS + OVH;
  localparam int KW       = $clog2(KERNEL);

  logic                      clk;
  logic                      rst;
  logic                      start;
  logic [ADDR_W-1:0]         base_row;
  logic [WL-1:0]             bias_in;
  logic                      busy;
  logic                      rd_en;
  logic [ADDR_W-1:0]         feat_addr;
  logic [KW-1:0]             filt_addr;
  logic [FEATURES*BITS-1:0]  feat_rd_data;
  logic [KERNEL*BITS-1:0]    filt_rd_data;
  logic [KERNEL*BITS-1:0]    dp_filters;
  logic [FEATURES*BITS-1:0]  dp_features;
  logic [NL*WL-1:0]          dp_biases;
  logic [NL*WL-1:0]          dp_sums;
  logic [NL*WL-1:0]          out_sums;
  logic                      out_valid;
  logic                      out_ready;
  logic [2:0]                dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] got_q[$];
  logic [KW-1:0]     fidx_q[$];
  logic [ADDR_W-1:0] exp_q[$];

  logic              feat_mode;
  logic [BITS-1:0]   feat_val;
  logic [BITS-1:0]   filt_val;

  conv_row_scheduler #(
    .BITS(BITS), .KERNEL(KERNEL), .FEATURES(FEATURES), .OVERHEAD_BITS(OVH),
    .PIPE_LAT(PIPE_LAT), .ADDR_W(ADDR_W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_row(base_row),
    .i_bias_in(bias_in), .o_busy(busy), .o_rd_en(rd_en), .o_feat_addr(feat_addr),
    .o_filt_addr(filt_addr), .i_feat_rd_data(feat_rd_data),
    .i_filt_rd_data(filt_rd_data), .o_dp_filters(dp_filters),
    .o_dp_features(dp_features), .o_dp_biases(dp_biases), .i_dp_sums(dp_sums),
    .o_out_sums(out_sums), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- row memories (1-cycle read) ----------------
  function automatic logic [FEATURES*BITS-1:0] make_feat();
    logic [FEATURES*BITS-1:0] r;
    for (int j = 0; j < FEATURES; j++)
      r[j*BITS +: BITS] = feat_mode ? BITS'(j) : feat_val;
    return r;
  endfunction

  function automatic logic [KERNEL*BITS-1:0] make_filt();
    logic [KERNEL*BITS-1:0] r;
    for (int t = 0; t < KERNEL; t++) r[t*BITS +: BITS] = filt_val;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      feat_rd_data <= make_feat();
      filt_rd_data <= make_filt();
      got_q.push_back(feat_addr);
      fidx_q.push_back(filt_addr);
    end
  end

  // ---------------- behavioural base_block ----------------
  function automatic logic [NL*WL-1:0] dp_compute(input logic [KERNEL*BITS-1:0] f,
                                                  input logic [FEATURES*BITS-1:0] x,
                                                  input logic [NL*WL-1:0] b);
    logic [NL*WL-1:0]      r;
    logic signed [WL-1:0]  acc;
    logic signed [2*BITS-1:0] p;
    for (int i = 0; i < NL; i++) begin
      acc = b[i*WL +: WL];
      for (int t = 0; t < KERNEL; t++) begin
        p   = $signed(f[t*BITS +: BITS]) * $signed(x[(i+t)*BITS +: BITS]);
        acc = acc + WL'(p);
      end
      r[i*WL +: WL] = acc;
    end
    return r;
  endfunction

  // Result is visible on the PIPE_LAT-th cycle of stable inputs.
  logic [NL*WL-1:0] dp_pipe [0:PIPE_LAT-2];
  always @(posedge clk) begin
    dp_pipe[0] <= dp_compute(dp_filters, dp_features, dp_biases);
    for (int s = 1; s < PIPE_LAT - 1; s++) dp_pipe[s] <= dp_pipe[s-1];
  end
  assign dp_sums = dp_pipe[PIPE_LAT-2];

  // ---------------- driver tasks ----------------
  // Called at a negedge while the DUT is idle; returns at the first out_valid cycle.
  task automatic run_to_valid(input logic [ADDR_W-1:0] base, input logic [WL-1:0] bias,
                              output int lat);
    got_q.delete();
    fidx_q.delete();
    start    = 1'b1;
    base_row = base;
    bias_in  = bias;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_row = '0; bias_in = '0;
    feat_mode = 1'b0; feat_val = '0; filt_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, rd_en, feat_addr, filt_addr, dp_filters, dp_features, dp_biases,
           out_sums, out_valid, dbg_state} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: busy=%b rd_en=%b out_valid=%b feat_addr=%0d out_sums=%h, required all zero",
                 c, busy, rd_en, out_valid, feat_addr, out_sums);
      end
    end
  endtask

  task automatic test_ones();
    int lat;
    feat_mode = 1'b0; feat_val = 16'd1; filt_val = 16'd1;
    @(negedge clk);
    run_to_valid(10'd100, WL'(5), lat);
    n_checks++;
    if (lat !== 57) begin
      n_fail++; $display("FAIL ones_latency: got %0d required 57", lat);
    end
    for (int i = 0; i < NL; i++) begin
      n_checks++;
      if (out_sums[i*WL +: WL] !== WL'(54)) begin
        n_fail++; $display("FAIL ones_lane%0d: got %0d required 54", i, out_sums[i*WL +: WL]);
      end
    end
    n_checks++;
    if (got_q.size() !== 7) begin
      n_fail++; $display("FAIL ones_rd_count: got %0d required 7", got_q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_checks++;
        if (got_q[i] !== ADDR_W'(100 + i) || fidx_q[i] !== KW'(i)) begin
          n_fail++;
          $display("FAIL ones_addr%0d: got feat=%0d filt=%0d required feat=%0d filt=%0d",
                   i, got_q[i], fidx_q[i], 100 + i, i);
        end
      end
    end
    do_handshake();
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ones_release: got busy=%b out_valid=%b required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_wrap();
    int lat;
    exp_q = '{10'd1021, 10'd1022, 10'd1023, 10'd0, 10'd1, 10'd2, 10'd3};
    feat_mode = 1'b1; filt_val = 16'd1;
    @(negedge clk);
    run_to_valid(10'd1021, WL'(0), lat);
    n_checks++;
    if (got_q.size() !== 7) begin
      n_fail++; $display("FAIL wrap_rd_count: got %0d required 7", got_q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL wrap_addr%0d: got %0d required %0d", i, got_q[i], exp_q[i]);
        end
      end
    end
    // Ramp features: each row adds 7i+21 to lane i.
    for (int i = 0; i < NL; i++) begin
      n_checks++;
      if (out_sums[i*WL +: WL] !== WL'(147 + 49 * i)) begin
        n_fail++; $display("FAIL wrap_lane%0d: got %0d required %0d", i, out_sums[i*WL +: WL], 147 + 49 * i);
      end
    end
    do_handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [WL-1:0] e;
    e = WL'(-51);
    feat_mode = 1'b0; feat_val = 16'd1; filt_val = 16'd1;
    @(negedge clk);
    run_to_valid(10'd7, WL'(-100), lat);
    for (int c = 0; c < 10; c++) begin
      start = (c == 3 || c == 4);
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_sums !== {NL{e}}) begin
        n_fail++;
        $display("FAIL hold cycle %0d: got valid=%b busy=%b sums=%h required 1 1 %h",
                 c, out_valid, busy, out_sums, {NL{e}});
      end
      @(negedge clk);
    end
    start = 1'b0;
    do_handshake();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: got busy=%b required 0", busy);
    end
    repeat (12) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || got_q.size() !== 7) begin
      n_fail++;
      $display("FAIL ignored_start: got busy=%b reads=%0d required 0 7", busy, got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    feat_mode = 1'b0; feat_val = 16'd1; filt_val = 16'd1;
    @(negedge clk);
    start = 1'b1; base_row = 10'd50; bias_in = WL'(5);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, rd_en, feat_addr, filt_addr, dp_filters, dp_features, dp_biases,
         out_sums, out_valid, dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b rd_en=%b state=%0d dp_biases=%h, required all zero",
               busy, rd_en, dbg_state, dp_biases);
    end
    feat_mode = 1'b1;
    run_to_valid(10'd200, WL'(3), lat);
    n_checks++;
    if (lat !== 57) begin
      n_fail++; $display("FAIL mid_reset_latency: got %0d required 57", lat);
    end
    for (int i = 0; i < NL; i++) begin
      n_checks++;
      if (out_sums[i*WL +: WL] !== WL'(150 + 49 * i)) begin
        n_fail++; $display("FAIL mid_reset_lane%0d: got %0d required %0d", i, out_sums[i*WL +: WL], 150 + 49 * i);
      end
    end
    do_handshake();
  endtask

  task automatic test_back_to_back();
    int lat;
    feat_mode = 1'b0; feat_val = 16'd1; filt_val = 16'd1;
    @(negedge clk);
    run_to_valid(10'd0, WL'(5), lat);
    do_handshake();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: got busy=%b required 0", busy);
    end
    // Next job starts in the first idle cycle; 7 rows * 7 taps * 2*3 = 294.
    feat_val = 16'd3; filt_val = 16'd2;
    run_to_valid(10'd40, WL'(0), lat);
    n_checks++;
    if (lat !== 57 || out_sums !== {NL{WL'(294)}}) begin
      n_fail++; $display("FAIL b2b_result: got lat=%0d sums=%h required 57 lanes=294", lat, out_sums);
    end
    do_handshake();
  endtask

  task automatic test_saturation();
    int lat;
    logic [WL-1:0] e;
`ifdef CONV_SAT_EN
    e = 44'h0007FFFFFFF;
`else
    e = 44'h00C3FCF0031;
`endif
    feat_mode = 1'b0; feat_val = 16'h7FFF; filt_val = 16'h7FFF;
    @(negedge clk);
    run_to_valid(10'd300, WL'(0), lat);
    for (int i = 0; i < NL; i++) begin
      n_checks++;
      if (out_sums[i*WL +: WL] !== e) begin
        n_fail++; $display("FAIL sat_lane%0d: got %h required %h", i, out_sums[i*WL +: WL], e);
      end
    end
    do_handshake();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ones();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
